// File: rtl/dense_layer_mac.sv
// dense_layer_mac: sequential fully-connected layer, out[j] = bias[j] + sum_i W[j][i]*x[i], one signed MAC per clock.
// Latency: first result IN_SIZE+1 cycles after the last input is accepted; IN_SIZE+2 cycles per neuron when out_ready is high.
// Backpressure: in_ready is low outside LOAD (input ignored); out_ready low holds the result and all outputs steady.
// Optional macro DENSE_LAYER_RELU_EN: clamp negative results to zero at the output (acc itself is untouched).
module dense_layer_mac #(
  parameter int    IN_SIZE      = 128,
  parameter int    OUT_SIZE     = 64,
  parameter int    IN_W         = 32,
  parameter int    W_W          = 16,
  parameter int    ACC_W        = 48,
  parameter string WEIGHTS_FILE = "",
  parameter string BIAS_FILE    = ""
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [IN_W-1:0]             in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [ACC_W-1:0]            out_data,
  output logic [$clog2(OUT_SIZE)-1:0] out_idx,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        busy
);

  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int JW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int AW = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1;
  localparam int PW = IN_W + W_W;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    BIAS = 2'd1,
    MAC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Parameter memories: written hierarchically, never reset.
  logic signed [W_W-1:0]   weight_matrix [OUT_SIZE*IN_SIZE];
  logic signed [ACC_W-1:0] bias_vector   [OUT_SIZE];
  logic signed [IN_W-1:0]  x_buf         [IN_SIZE];

  state_t                  state_q;
  state_t                  state_d;
  logic [IW-1:0]           in_idx;
  logic [IW-1:0]           i;
  logic [JW-1:0]           j;
  logic signed [ACC_W-1:0] acc;

  logic                    load_fire;
  logic                    last_in;
  logic                    last_i;
  logic                    last_j;
  logic [AW-1:0]           waddr;
  logic signed [W_W-1:0]   w_cur;
  logic signed [IN_W-1:0]  x_cur;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] mac_term;

  assign last_in   = (in_idx == IW'(IN_SIZE - 1));
  assign last_i    = (i == IW'(IN_SIZE - 1));
  assign last_j    = (j == JW'(OUT_SIZE - 1));
  assign load_fire = in_valid && in_ready;

  // Multiply path: the full IN_W+W_W product is formed, then sign-extended into the accumulator.
  assign waddr    = AW'(j) * AW'(IN_SIZE) + AW'(i);
  assign w_cur    = weight_matrix[waddr];
  assign x_cur    = x_buf[i];
  assign prod     = PW'(w_cur) * PW'(x_cur);
  assign mac_term = ACC_W'(prod);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      LOAD: begin
        busy     = 1'b0;
        in_ready = !rst;
        if (in_valid && !rst && last_in) state_d = BIAS;
      end
      BIAS: state_d = MAC;
      MAC: begin
        if (last_i) state_d = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = last_j ? LOAD : BIAS;
      end
      default: state_d = LOAD;
    endcase
  end

  // Index counters and accumulator; reset abandons any vector in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_idx <= '0;
      i      <= '0;
      j      <= '0;
      acc    <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (load_fire) begin
            if (last_in) begin
              in_idx <= '0;
              j      <= '0;
            end else begin
              in_idx <= in_idx + IW'(1);
            end
          end
        end
        BIAS: begin
          acc <= bias_vector[j];
          i   <= '0;
        end
        MAC: begin
          acc <= acc + mac_term;
          i   <= i + IW'(1);
        end
        OUT: begin
          if (out_ready && !last_j) j <= j + JW'(1);
        end
        default: ;
      endcase
    end
  end

  // Input buffer capture; only written while loading, contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == LOAD && load_fire) x_buf[in_idx] <= in_data;
  end

  assign out_idx  = j;
  assign out_last = (state_q == OUT) && last_j;

`ifdef DENSE_LAYER_RELU_EN
  assign out_data = acc[ACC_W-1] ? '0 : acc;
`else
  assign out_data = acc;
`endif

endmodule

// File: tb/tb_dense_layer_mac.sv
// Bench for dense_layer_mac: a small (4x2) and a default-size (128x64) instance share one stimulus path.
// Expected results are queued when a vector is loaded and popped at each output handshake.
// Scenarios: reset, basic MAC, extremes/wrap, backpressure, input stall/ignore, reset mid-MAC, default-size timing.
module tb_dense_layer_mac;

  localparam int SN = 4;
  localparam int SM = 2;
  localparam int BN = 128;
  localparam int BM = 64;
`ifdef DENSE_LAYER_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_last, s_busy;
  logic [47:0] s_out_data;
  logic [0:0]  s_out_idx;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_last, b_busy;
  logic [47:0] b_out_data;
  logic [5:0]  b_out_idx;

  logic        o_valid, o_last, o_in_ready, o_busy;
  logic [47:0] o_data;
  logic [5:0]  o_idx;

  assign s_in_valid = in_valid & ~sel;
  assign b_in_valid = in_valid & sel;
  assign o_valid    = sel ? b_out_valid : s_out_valid;
  assign o_last     = sel ? b_out_last  : s_out_last;
  assign o_in_ready = sel ? b_in_ready  : s_in_ready;
  assign o_busy     = sel ? b_busy      : s_busy;
  assign o_data     = sel ? b_out_data  : s_out_data;
  assign o_idx      = sel ? b_out_idx   : {5'd0, s_out_idx};

  dense_layer_mac #(.IN_SIZE(SN), .OUT_SIZE(SM)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(in_data), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_idx(s_out_idx), .out_last(s_out_last),
    .out_ready(out_ready), .busy(s_busy));

  dense_layer_mac dut_big (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last),
    .out_ready(out_ready), .busy(b_busy));

  typedef struct {
    logic [5:0]  idx;
    logic [47:0] data;
    logic        last;
  } exp_t;

  exp_t               sb[$];
  int                 n_cur, m_cur;
  int                 xs[BN];
  int                 ws[BN*BM];
  logic signed [47:0] bs[BM];
  int                 n_checks = 0;
  int                 n_fail = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] golden(input int jj);
    logic signed [47:0] a;
    a = bs[jj];
    for (int ii = 0; ii < n_cur; ii++)
      a = a + 48'(longint'(xs[ii]) * longint'(ws[jj*n_cur+ii]));
    if (RELU && a < 0) a = '0;
    return a;
  endfunction

  task automatic randomize_vec;
    for (int e = 0; e < n_cur; e++) xs[e] = int'($urandom);
    for (int k = 0; k < n_cur*m_cur; k++) ws[k] = int'(shortint'($urandom));
    for (int jj = 0; jj < m_cur; jj++) bs[jj] = 48'({$urandom, $urandom});
  endtask

  task automatic program_dut;
    for (int k = 0; k < n_cur*m_cur; k++) begin
      if (sel) dut_big.weight_matrix[k] = 16'(ws[k]);
      else     dut_small.weight_matrix[k] = 16'(ws[k]);
    end
    for (int jj = 0; jj < m_cur; jj++) begin
      if (sel) dut_big.bias_vector[jj] = bs[jj];
      else     dut_small.bias_vector[jj] = bs[jj];
    end
  endtask

  task automatic push_golden;
    for (int jj = 0; jj < m_cur; jj++)
      sb.push_back('{6'(jj), golden(jj), (jj == m_cur - 1)});
  endtask

  // Returns at #1 after the edge that accepted the last element.
  task automatic load_vec(input bit gaps);
    int guard;
    for (int e = 0; e < n_cur; e++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick;
      end
      in_valid = 1'b1;
      in_data  = xs[e];
      guard = 0;
      while (!o_in_ready && guard < 20) begin
        tick;
        guard++;
      end
      if (guard >= 20) begin
        n_checks++; n_fail++;
        $display("FAIL load_timeout: in_ready stayed %0b, required 1 at element %0d", o_in_ready, e);
      end
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n_take, input int hold, input bit junk, input bit timing);
    int   k = 0;
    int   got = 0;
    int   limit;
    bit   first = 1'b1;
    exp_t e;
    limit = m_cur * (n_cur + 2) + hold + 50;
    while (got < n_take && k < limit) begin
      if (junk) begin
        in_valid = 1'b1;
        in_data  = 32'hDEAD;
      end
      out_ready = 1'b1;
      if (o_valid && first) begin
        first = 1'b0;
        if (timing) begin
          n_checks++;
          if (k !== n_cur + 1) begin
            n_fail++;
            $display("FAIL first_latency: got %0d cycles, required %0d", k, n_cur + 1);
          end
        end
        for (int h = 0; h < hold; h++) begin
          out_ready = 1'b0;
          n_checks++;
          if (o_valid !== 1'b1 || o_in_ready !== 1'b0 || sb.size() == 0 ||
              o_data !== sb[0].data || o_idx !== sb[0].idx) begin
            n_fail++;
            $display("FAIL hold_stable: cycle %0d valid=%0b in_ready=%0b data=%0h idx=%0d, required valid=1 in_ready=0 data/idx of pending result",
                     h, o_valid, o_in_ready, o_data, o_idx);
          end
          tick;
          k++;
        end
        out_ready = 1'b1;
      end
      if (o_valid && out_ready) begin
        got++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: idx=%0d data=%0h, required no output", o_idx, o_data);
        end else begin
          e = sb.pop_front();
          if (o_data !== e.data || o_idx !== e.idx || o_last !== e.last) begin
            n_fail++;
            $display("FAIL result: got idx=%0d data=%0h last=%0b, required idx=%0d data=%0h last=%0b",
                     o_idx, o_data, o_last, e.idx, e.data, e.last);
          end
        end
        if (got == n_take) in_valid = 1'b0;
      end
      tick;
      k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (got < n_take) begin
      n_checks++; n_fail++;
      $display("FAIL collect_timeout: got %0d results, required %0d", got, n_take);
    end else if (n_take == m_cur) begin
      n_checks++;
      if (o_in_ready !== 1'b1 || o_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL back_to_load: in_ready=%0b busy=%0b, required 1/0", o_in_ready, o_busy);
      end
      if (timing) begin
        n_checks++;
        if (k !== m_cur * (n_cur + 2) + hold) begin
          n_fail++;
          $display("FAIL vector_cycles: got %0d, required %0d", k, m_cur * (n_cur + 2) + hold);
        end
      end
    end
  endtask

  task automatic test_reset;
    sel = 1'b0;
    rst = 1'b1;
    repeat (2) tick;
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_data !== 48'd0 || o_idx !== 6'd0 || o_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%0b busy=%0b data=%0h idx=%0d last=%0b, required all zero",
               o_valid, o_busy, o_data, o_idx, o_last);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %0b, required 1", o_in_ready);
    end
    tick;
  endtask

  task automatic test_basic;
    sel = 1'b0; n_cur = SN; m_cur = SM;
    xs[0] = 1; xs[1] = 2; xs[2] = 3; xs[3] = 4;
    ws[0] = 1; ws[1] = 1; ws[2] = 1; ws[3] = 1;
    ws[4] = 2; ws[5] = 0; ws[6] = 0; ws[7] = -1;
    bs[0] = 48'sd10; bs[1] = 48'sd0;
    program_dut;
    load_vec(1'b0);
    sb.push_back('{6'd0, 48'd20, 1'b0});
    sb.push_back('{6'd1, RELU ? 48'd0 : 48'hFFFF_FFFF_FFFE, 1'b1});
    collect(SM, 0, 1'b0, 1'b1);
  endtask

  task automatic test_extremes;
    sel = 1'b0; n_cur = SN; m_cur = SM;
    for (int e = 0; e < SN; e++) xs[e] = 32'h7FFF_FFFF;
    for (int k = 0; k < SN*SM; k++) ws[k] = 32'h0000_7FFF;
    bs[0] = '0; bs[1] = '0;
    program_dut;
    load_vec(1'b0);
    sb.push_back('{6'd0, RELU ? 48'd0 : 48'hFFFD_FFFE_0004, 1'b0});
    sb.push_back('{6'd1, RELU ? 48'd0 : 48'hFFFD_FFFE_0004, 1'b1});
    collect(SM, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure;
    sel = 1'b0; n_cur = SN; m_cur = SM;
    randomize_vec;
    program_dut;
    load_vec(1'b0);
    push_golden;
    collect(SM, 50, 1'b0, 1'b1);
  endtask

  task automatic test_stall_ignore;
    sel = 1'b0; n_cur = SN; m_cur = SM;
    for (int r = 0; r < 3; r++) begin
      randomize_vec;
      program_dut;
      load_vec(1'b1);
      push_golden;
      collect(SM, 0, 1'b1, 1'b0);
    end
  endtask

  task automatic test_reset_mid_mac;
    sel = 1'b0; n_cur = SN; m_cur = SM;
    randomize_vec;
    program_dut;
    load_vec(1'b0);
    push_golden;
    collect(1, 0, 1'b0, 1'b0);
    repeat (2) tick;
    rst = 1'b1;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%0b busy=%0b, required 0/0", o_valid, o_busy);
    end
    sb.delete();
    tick;
    rst = 1'b0;
    #1;
    n_checks++;
    if (o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_in_ready: got %0b, required 1", o_in_ready);
    end
    tick;
    randomize_vec;
    program_dut;
    load_vec(1'b0);
    push_golden;
    collect(SM, 0, 1'b0, 1'b1);
  endtask

  task automatic test_default_params;
    sel = 1'b1; n_cur = BN; m_cur = BM;
    #1;
    randomize_vec;
    program_dut;
    load_vec(1'b0);
    push_golden;
    collect(BM, 0, 1'b0, 1'b1);
    sel = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    sel       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    n_cur     = SN;
    m_cur     = SM;
    test_reset;
    test_basic;
    test_extremes;
    test_backpressure;
    test_stall_ignore;
    test_reset_mid_mac;
    test_default_params;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
